// File: rtl/line_fill_buffer.sv
// Line fill buffer: captures a burst of up to 16 words into a register line,
// then presents them in order to a downstream 16:1 word mux via sel.
module line_fill_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [DEPTH*DATA_W-1:0] line_data,
    output logic [3:0]              sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [4:0]              len,
    output logic                    ovf_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] wptr_q;
    logic [3:0] rptr_q;
    logic [4:0] len_q;
    logic       ovf_q;

    logic [3:0] wptr_d;
    logic [3:0] rptr_d;
    logic       accept;
    logic       last_word;

    // flush outranks every beat, so a beat in the flush cycle never lands
    assign accept    = (state_q == FILL) && in_valid && !flush;
    assign wptr_d    = wptr_q + 4'd1;
    assign rptr_d    = rptr_q + 4'd1;
    assign last_word = ({1'b0, rptr_q} == (len_q - 5'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= 4'd0;
            rptr_q  <= 4'd0;
            len_q   <= 5'd0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            wptr_q  <= 4'd0;
            rptr_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FILL;
                        wptr_q  <= 4'd0;
                        rptr_q  <= 4'd0;
                        ovf_q   <= 1'b0;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        wptr_q <= wptr_d;
                        if (in_last) begin
                            len_q   <= {1'b0, wptr_q} + 5'd1;
                            state_q <= DRAIN;
                            rptr_q  <= 4'd0;
                        end else if (wptr_q == 4'd15) begin
                            // line full without a terminating beat
                            len_q   <= 5'd16;
                            ovf_q   <= 1'b1;
                            state_q <= DRAIN;
                            rptr_q  <= 4'd0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        rptr_q <= rptr_d;
                        if (last_word) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= '0;
                end else if (accept && (wptr_q == 4'(gi))) begin
                    entry_q <= in_data;
                end
            end

            assign line_data[gi*DATA_W +: DATA_W] = entry_q;
        end
    endgenerate

    // handshake outputs are forced low for the whole reset cycle
    assign in_ready  = !rst && (state_q == FILL);
    assign out_valid = !rst && (state_q == DRAIN);
    assign sel       = out_valid ? rptr_q : 4'd0;
    assign out_last  = out_valid && last_word;
    assign len       = len_q;
    assign ovf_err   = ovf_q;

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 Parameter: DATA_W, 32, word width in bits.
REQ-002 Parameter: DEPTH, 16, entry count; fixed at 16 so the 4-bit index selects every entry.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new fill; honoured only in IDLE.
REQ-006 flush  input  1  synchronous abort to IDLE; honoured in any state.
REQ-007 in_valid  input  1  fill beat present.
REQ-008 in_data  input  DATA_W  fill beat payload.
REQ-009 in_last  input  1  final beat of the burst.
REQ-010 in_ready  output  1  buffer accepts a fill beat.
REQ-011 line_data  output  DEPTH*DATA_W  packed entries; entry k at bits [k*DATA_W +: DATA_W], for a downstream 16:1 word mux.
REQ-012 sel  output  4  drain index, driven to the downstream mux select.
REQ-013 out_valid  output  1  current sel word is valid for consumption.
REQ-014 out_ready  input  1  consumer takes the current word.
REQ-015 out_last  output  1  current word is the final word of the line.
REQ-016 len  output  5  beats captured in the last fill, range 1..16.
REQ-017 ovf_err  output  1  sticky; a 16th beat was accepted without in_last.

Function
REQ-018 States SHALL be IDLE, FILL and DRAIN, held in registers.
REQ-019 IDLE with start=1 SHALL go to FILL next cycle with wptr=0; start SHALL be ignored in FILL and DRAIN.
REQ-020 in_ready SHALL be 1 only in FILL; a beat is accepted when in_valid and in_ready are both 1.
REQ-021 An accepted beat SHALL write in_data to entry[wptr], then increment wptr.
REQ-022 A beat accepted with in_last=1 SHALL set len=wptr+1 and move to DRAIN next cycle.
REQ-023 A beat accepted at wptr=15 with in_last=0 SHALL set len=16, set ovf_err and move to DRAIN.
REQ-024 Beats with in_last=1 in any state other than FILL SHALL be ignored.
REQ-025 DRAIN SHALL enter with rptr=0.
REQ-026 In DRAIN, out_valid SHALL be 1 and sel SHALL equal rptr.
REQ-027 In DRAIN, out_last SHALL be 1 when rptr==len-1.
REQ-028 A drain handshake (out_valid and out_ready both 1) SHALL increment rptr.
REQ-029 A drain handshake with out_last=1 SHALL return to IDLE next cycle.
REQ-030 out_valid SHALL be 0 in IDLE and FILL; out_valid and sel SHALL hold stable while out_ready=0.
REQ-031 Latency: first out_valid SHALL occur exactly one cycle after the final fill beat is accepted.
REQ-032 The minimum cycle count from start to return to IDLE is 1 + len + len.
REQ-033 In IDLE, sel SHALL be 0.
REQ-034 line_data SHALL retain contents across IDLE; entries not written by a short burst keep their prior values.
REQ-035 flush SHALL force IDLE next cycle, clear wptr and rptr, and leave entries, len and ovf_err unchanged.
REQ-036 flush SHALL take priority over start, fill beats and drain handshakes in the same cycle.
REQ-037 ovf_err SHALL be cleared only by rst or by a start accepted in IDLE.

Reset
REQ-038 While rst=1, next cycle state SHALL be IDLE and wptr, rptr and sel SHALL be 0.
REQ-039 While rst=1, all entries, len and ovf_err SHALL be 0, and in_ready, out_valid and out_last SHALL be 0.
REQ-040 rst SHALL override flush, start and all handshakes, including when asserted mid-FILL or mid-DRAIN.

Verification
REQ-041 Full burst: 16 beats 0x1000..0x100F, in_last on beat 16, out_ready=1.
- Required: 16 words drained in order, sel 0..15, out_last only at sel=15, len=16, ovf_err=0.
REQ-042 Short burst with backpressure: 3 beats 0xA, 0xB, 0xC with in_last on beat 3; out_ready toggles 1/0.
- Required: len=3; sel and out_valid hold while out_ready=0; out_last at sel=2; entries 3..15 unchanged.
REQ-043 Overflow: 16 beats with in_last never asserted.
- Required: DRAIN entered after beat 16, ovf_err=1, in_ready=0; a 17th in_valid is not accepted.
REQ-044 flush at beat 5 of FILL, start in the same cycle.
- Required: IDLE next cycle, start ignored, wptr=0, entries 0..4 retained.
REQ-045 rst at sel=7 of DRAIN.
- Required: next cycle IDLE, line_data all 0, len=0, out_valid=0.
REQ-046 in_valid=1 in IDLE with start=0.
- Required: in_ready=0, no entry written.
